// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// FSM encoding, reset vector and instruction field positions.
package mips_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Upper bit of the jump index and branch offset fields.
    localparam int JUMP_HI   = 25;
    localparam int BRANCH_HI = 15;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC computation: sequential, branch target and jump target.
// Purely combinational; jump outranks a taken branch.
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        unused_opcode;

    assign pc_plus4 = pc + 32'd4;

    assign branch_off = {{14{instr[BRANCH_HI]}},
                         instr[BRANCH_HI:0], 2'b00};

    assign branch_target = pc_plus4 + branch_off;

    assign jump_target = {pc_plus4[31:28],
                          instr[JUMP_HI:0], 2'b00};

    // Opcode bits are the decoder's concern, not ours.
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, handshakes with imem,
// holds the fetched word until the datapath advances.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] retired
);

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    fetch_state_t state_n;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic [31:0] next_pc;
    logic        take_word;
    logic        retire;

    pc_next u_pc_next (
        .pc           (pc_q),
        .instr        (instr_q),
        .branch_taken (branch_taken),
        .jump         (jump),
        .next_pc      (next_pc),
        .pc_plus4     (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        imem_req  = 1'b0;
        take_word = 1'b0;
        retire    = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    take_word = 1'b1;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= START_PC;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            if (take_word) begin
                instr_q <= imem_rdata;
            end
            if (retire) begin
                // Low bits cleared so pc stays word aligned.
                pc_q      <= {next_pc[31:2], 2'b00};
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state == HOLD);
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of
// expected fetched words and expected next PCs.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        branch_taken;
    logic        jump;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] cur_pc;
    logic [31:0] exp_ret;

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .advance      (advance),
        .branch_taken (branch_taken),
        .jump         (jump),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_ret"}, retired, 32'h0);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h1);
        chk({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    // Wait lat cycles, then ack with rdata; noise pulses
    // advance/jump/branch during the wait.
    task automatic fetch(input logic [31:0] rdata,
                         input int lat,
                         input logic noise);
        for (int i = 0; i < lat; i++) begin
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, cur_pc);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
            advance      = noise;
            jump         = noise;
            branch_taken = noise;
            tick();
            advance      = 1'b0;
            jump         = 1'b0;
            branch_taken = 1'b0;
            chk("wait_pc", pc, cur_pc);
            chk("wait_ret", retired, exp_ret);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_instr_q.push_back(rdata);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_valid", {31'b0, instr_valid}, 32'h1);
        chk("hold_instr", instr, exp_instr_q.pop_front());
        chk("hold_pc", pc, cur_pc);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_p4", pc_plus4, cur_pc + 32'd4);
    endtask

    task automatic step(input logic bt,
                        input logic j,
                        input logic [31:0] nxt);
        advance      = 1'b1;
        branch_taken = bt;
        jump         = j;
        exp_pc_q.push_back(nxt);
        tick();
        advance      = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        cur_pc  = exp_pc_q.pop_front();
        exp_ret = exp_ret + 32'd1;
        chk("adv_pc", pc, cur_pc);
        chk("adv_ret", retired, exp_ret);
        chk("adv_valid", {31'b0, instr_valid}, 32'h0);
        chk("adv_req", {31'b0, imem_req}, 32'h1);
        chk("adv_addr", imem_addr, cur_pc);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        advance      = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        cur_pc       = 32'h0;
        exp_ret      = 32'h0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Same-cycle ack right after release.
        fetch(32'h2008_0005, 0, 1'b0);
        step(1'b0, 1'b0, 32'h4);

        // 3-cycle latency with advance noise, then jump to 0x40.
        fetch(32'h0800_0010, 3, 1'b1);
        step(1'b0, 1'b1, 32'h40);

        // Taken branch back by 8, then not-taken.
        fetch(32'h1000_FFFE, 1, 1'b0);
        step(1'b1, 1'b0, 32'h3C);
        fetch(32'h0000_0020, 0, 1'b0);
        step(1'b0, 1'b0, 32'h40);
        fetch(32'h1000_FFFE, 2, 1'b0);
        step(1'b0, 1'b0, 32'h44);

        // Climb to 0x1000_0000, then jump+branch together.
        fetch(32'h0BFF_FFFE, 0, 1'b0);
        step(1'b0, 1'b1, 32'h0FFF_FFF8);
        fetch(32'h0000_0020, 0, 1'b0);
        step(1'b0, 1'b0, 32'h0FFF_FFFC);
        fetch(32'h0000_0020, 1, 1'b0);
        step(1'b0, 1'b0, 32'h1000_0000);
        fetch(32'h0800_0010, 0, 1'b0);
        step(1'b1, 1'b1, 32'h1000_0040);

        // Reset mid-wait with a stale ack while held low.
        fetch(32'h0000_0000, 0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        chk_reset("stale");
        imem_ack = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        cur_pc  = 32'h0;
        exp_ret = 32'h0;
        #1;

        // Fresh fetch of the reset PC, then wrap via negative branch.
        fetch(32'h1000_FFFE, 1, 1'b0);
        step(1'b1, 1'b0, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, 2, 1'b1);
        step(1'b0, 1'b0, 32'h0);

        chk("q_instr_empty", exp_instr_q.size(), 32'h0);
        chk("q_pc_empty", exp_pc_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Cycle budget guard.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle-control MIPS core, directly upstream of the instruction decoder. It owns the program counter and runs a request/acknowledge handshake to instruction memory of arbitrary latency. It holds each fetched word stable for the decoder and datapath. When the datapath signals completion, it computes the next PC from the held instruction and the decoder's branch/jump outcome.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the word being fetched; equals `pc`.
- imem_ack  in  1  memory returns a word this cycle; sampled only while `imem_req`=1.
- imem_rdata  in  32  instruction word; valid when `imem_ack`=1.
- instr  out  32  held instruction, driven to the decoder.
- instr_valid  out  1  `instr` holds a fetched word for the current `pc`.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  `pc`+4, modulo 2^32.
- advance  in  1  datapath has completed the current instruction; honoured only while `instr_valid`=1.
- branch_taken  in  1  branch decoded and condition true (`branch & zero`); sampled with `advance`.
- jump  in  1  jump decoded; sampled with `advance`.
- retired  out  32  count of instructions retired; wraps modulo 2^32.

## Operation
- Two-state FSM: FETCH and HOLD.
- FETCH:
  - `imem_req`=1 and `instr_valid`=0.
  - `imem_addr`=`pc`, held stable until ack.
  - On `imem_ack`=1, `instr` <= `imem_rdata` and the FSM goes to HOLD.
- HOLD:
  - `imem_req`=0 and `instr_valid`=1.
  - `instr` and `pc` are frozen.
  - On `advance`=1, `pc` <= next_pc, `retired` <= `retired`+1, and the FSM goes to FETCH.
- next_pc, in priority order:
  - `jump`: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else `branch_taken`: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
- `jump` wins when `jump` and `branch_taken` are both 1.
- All adds are 32-bit and modular; carry-out is discarded.
  - `pc` 32'hFFFF_FFFC + 4 gives 0.
  - A negative branch offset wraps below 0.
- `pc[1:0]` is always 2'b00. RESET_PC[1:0] is forced to 0.
- `advance`, `branch_taken` and `jump` are ignored in FETCH.
- `imem_ack` is ignored in HOLD, and whenever `imem_req`=0.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - `pc`=RESET_PC and `instr`=32'h0.
  - `instr_valid`=0 and `retired`=0.
  - FSM=FETCH, so `imem_req`=1 and `imem_addr`=RESET_PC.
- An ack in the first cycle after release is legal.
- Minimum 2 cycles per instruction: one FETCH cycle with same-cycle ack, then one HOLD cycle with `advance`.
- `imem_ack` may arrive any number of cycles after request; `imem_req` and `imem_addr` do not change while waiting.
- `instr_valid` rises the cycle after the ack edge.
- `pc` changes the cycle after the `advance` edge, and `instr_valid` falls in that same cycle.
- Reset mid-fetch aborts the request immediately; `imem_req` stays high on the new RESET_PC.
  - Instruction memory shares `rst_n` and drops any outstanding ack.
- Reset in HOLD discards the held word; `retired` is not incremented.

## Structure
- Shared package `mips_pkg`:
  - FSM state enum {FETCH, HOLD}.
  - Default reset vector constant.
  - Jump and branch field slice constants: [25:0] and [15:0].
- Sub-module `pc_next`: purely combinational next-PC adder and priority mux.
  - Inputs: pc, instr, branch_taken, jump.
  - Outputs: next_pc, pc_plus4.
  - Unit-tested separately.
- Top-level: FSM, `pc`/`instr`/`retired` registers, memory handshake.

## Test plan
- Reset release, ack same cycle with rdata 32'h2008_0005 -> `instr`=32'h2008_0005, `instr_valid`=1, `pc`=0 in the next cycle; `advance` -> `pc`=4, `retired`=1.
- Memory latency 3 cycles -> `imem_req`=1 and `imem_addr`=4 held for 3 cycles; `instr_valid` stays 0 until the cycle after the ack.
- Branch: `pc`=32'h40, instr 32'h1000_FFFE, `advance` with `branch_taken`=1 -> `pc`=32'h3C; same with `branch_taken`=0 -> `pc`=32'h44.
- Jump and branch: `pc`=32'h1000_0000, instr 32'h0800_0010, `advance` with `jump`=1 and `branch_taken`=1 -> `pc`=32'h1000_0040 (jump wins).
- Wrap:
  - `pc`=32'hFFFF_FFFC, plain advance -> `pc`=0.
  - `advance` pulsed during FETCH -> no change to `pc` or `retired`.
- `rst_n` low mid-wait, then a stale ack while reset is low -> all outputs at reset values; a fresh fetch of RESET_PC follows release.
